cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 4: number of functional-unit result ports (fixed at 4; rr pointer 2 bits).
REQ-002 SHALL have parameter DATA_W, default 64: result data width.
REQ-003 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  in  1  mispredict squash; discards all held results.
REQ-006 SHALL have port fu_valid  in  NUM_FU  per-port result valid.
REQ-007 SHALL have port fu_tag  in  NUM_FU x PHYS_REG  per-port destination physical register.
REQ-008 SHALL have port fu_data  in  NUM_FU x DATA_W  per-port result value.
REQ-009 SHALL have port fu_ready  out  NUM_FU  per-port accept; transfer when fu_valid & fu_ready at posedge.
REQ-010 SHALL have ports wra_en/wrb_en  out  1 each  regfile write-port enables.
REQ-011 SHALL have ports wra_idx/wrb_idx  out  PHYS_REG each  regfile write indices, doubling as CDB tags.
REQ-012 SHALL have ports wra_data/wrb_data  out  DATA_W each  regfile write data.

Function
REQ-013 SHALL keep one holding register per port (hold_valid, tag, data).
REQ-014 SHALL grant at most 2 held entries per cycle; first grant drives port a, second drives port b.
REQ-015 SHALL scan ports in round-robin order starting at rr_ptr: rr_ptr, rr_ptr+1, ... mod 4.
REQ-016 SHALL update rr_ptr at posedge to (last granted index + 1) mod 4 when any grant occurs, else hold.
REQ-017 SHALL drive wr*_en/idx/data combinationally from granted holding registers; granted result written to regfile at the next posedge (1 cycle from acceptance to write edge).
REQ-018 SHALL drive idx = PHYS_ZERO_REG and data = 0 on any port whose en is low.
REQ-019 SHALL assert fu_ready[i] = ~hold_valid[i] | grant[i] (accept when empty or draining this cycle); fu_ready SHALL be low while flush or reset is high.
REQ-020 SHALL clear hold_valid[i] on grant, or reload it when a new result is accepted in the same cycle.
REQ-021 SHALL accept, and silently drop (never hold, never grant), a result whose fu_tag == PHYS_ZERO_REG.
REQ-022 SHALL, when only one entry is held, use port a only; wrb_en low.
REQ-023 SHALL never grant the same holding register twice in one cycle; with 3-4 entries held, ungranted entries retain value and fu_ready stays low for them.
REQ-024 SHALL, while flush is high, drive wra_en = wrb_en = 0, and clear all hold_valid at the posedge; rr_ptr unchanged.
REQ-025 SHALL never emit wra_idx == wrb_idx with both enables high (distinct tags are guaranteed by rename; no merging logic).

Reset
REQ-026 SHALL on reset clear all hold_valid, set rr_ptr = 0, drive wra_en = wrb_en = 0, idx = PHYS_ZERO_REG, data = 0, fu_ready = 0.
REQ-027 SHALL give reset priority over flush and over any simultaneous fu_valid; results presented during reset are lost.
REQ-028 SHALL after reset deassertion assert fu_ready = all ones in the first cycle.

Configuration
REQ-029 SHALL support macro CDB_BYPASS_EN.
REQ-030 SHALL, with CDB_BYPASS_EN defined, treat an empty port with fu_valid (non-zero tag) as a grant candidate in the same cycle; if granted, its result drives wr* combinationally from fu_* and is not held (0-cycle latency).
REQ-031 SHALL, without CDB_BYPASS_EN, only grant from holding registers (1-cycle latency per REQ-017).

Verification
REQ-032 SHALL cover: reset then fu_valid=0001, tag 5, data 0xAA -> next cycle wra_en=1, idx 5, data 0xAA, wrb_en=0; regfile reads 0xAA from reg 5 after following edge.
REQ-033 SHALL cover: all 4 ports valid, tags 10..13, rr_ptr=0 -> cycle 1 writes 10,11; cycle 2 writes 12,13; rr_ptr ends at 0; fu_ready for ports 2,3 low in cycle 1.
REQ-034 SHALL cover: port 0 continuously valid and ports 1-3 held -> every port granted within 2 cycles (no starvation).
REQ-035 SHALL cover: fu_tag = PHYS_ZERO_REG, data 7 on port 2 -> fu_ready=1, no write enable ever asserted for it.
REQ-036 SHALL cover: 3 entries held, flush pulsed -> wra_en=wrb_en=0 that cycle, nothing written afterward, fu_ready all ones next cycle.
REQ-037 SHALL cover: with CDB_BYPASS_EN, empty arbiter, port 1 valid tag 20 data 15 -> wra_en=1, idx 20, data 15 in the same cycle; without the macro, one cycle later.

Source files
------------

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Common-data-bus arbiter. Holds one completed result per
//                functional-unit port and drains at most two per cycle onto
//                the two register-file write ports in round-robin order.
//                Optional macro CDB_BYPASS_EN lets an empty port's incoming
//                result be granted in the cycle it arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int                  NUM_FU        = 4,
  parameter int                  DATA_W        = 64,
  parameter int                  PHYS_REG      = 7,
  parameter logic [PHYS_REG-1:0] PHYS_ZERO_REG = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_FU-1:0]          fu_valid,
  input  logic [NUM_FU*PHYS_REG-1:0] fu_tag,
  input  logic [NUM_FU*DATA_W-1:0]   fu_data,
  output logic [NUM_FU-1:0]          fu_ready,
  output logic                       wra_en,
  output logic                       wrb_en,
  output logic [PHYS_REG-1:0]        wra_idx,
  output logic [PHYS_REG-1:0]        wrb_idx,
  output logic [DATA_W-1:0]          wra_data,
  output logic [DATA_W-1:0]          wrb_data
);

  // Four ports, so the round-robin pointer wraps naturally in two bits.
  localparam int PTR_W = 2;

  logic [NUM_FU-1:0]   hold_valid_q, hold_valid_d;
  logic [PHYS_REG-1:0] hold_tag_q  [NUM_FU];
  logic [PHYS_REG-1:0] hold_tag_d  [NUM_FU];
  logic [DATA_W-1:0]   hold_data_q [NUM_FU];
  logic [DATA_W-1:0]   hold_data_d [NUM_FU];
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [PHYS_REG-1:0] in_tag   [NUM_FU];
  logic [DATA_W-1:0]   in_data  [NUM_FU];
  logic [NUM_FU-1:0]   in_live;
  logic [NUM_FU-1:0]   cand;
  logic [PHYS_REG-1:0] src_tag  [NUM_FU];
  logic [DATA_W-1:0]   src_data [NUM_FU];
  logic [NUM_FU-1:0]   grant;
  logic                gnt_a_vld, gnt_b_vld;
  logic [PTR_W-1:0]    gnt_a_idx, gnt_b_idx, scan_idx;
  logic                arb_off;

  // Reset and flush both silence the bus and block acceptance.
  assign arb_off = reset | flush;

  generate
    for (genvar g = 0; g < NUM_FU; g++) begin : g_unpack
      assign in_tag[g]  = fu_tag[g*PHYS_REG +: PHYS_REG];
      assign in_data[g] = fu_data[g*DATA_W +: DATA_W];
      // A zero-tag result has no architectural destination and is dropped.
      assign in_live[g] = fu_valid[g] & (in_tag[g] != PHYS_ZERO_REG);
    end
  endgenerate

  // Grant candidates and the tag/data each candidate would put on the bus.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_FU; i++) begin
`ifdef CDB_BYPASS_EN
      cand[i]     = ~arb_off & (hold_valid_q[i] | in_live[i]);
      src_tag[i]  = hold_valid_q[i] ? hold_tag_q[i]  : in_tag[i];
      src_data[i] = hold_valid_q[i] ? hold_data_q[i] : in_data[i];
`else
      cand[i]     = ~arb_off & hold_valid_q[i];
      src_tag[i]  = hold_tag_q[i];
      src_data[i] = hold_data_q[i];
`endif
    end
  end

  // Round-robin scan from rr_ptr: first hit drives port a, second port b.
  always_comb begin
    grant     = '0;
    gnt_a_vld = 1'b0;
    gnt_b_vld = 1'b0;
    gnt_a_idx = '0;
    gnt_b_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_idx = rr_ptr_q + PTR_W'(k);
      if (cand[scan_idx] && !gnt_b_vld) begin
        if (!gnt_a_vld) begin
          gnt_a_vld = 1'b1;
          gnt_a_idx = scan_idx;
        end else begin
          gnt_b_vld = 1'b1;
          gnt_b_idx = scan_idx;
        end
        grant[scan_idx] = 1'b1;
      end
    end
  end

  // Write ports and per-port accept; idle write ports present zero.
  always_comb begin
    wra_en   = gnt_a_vld;
    wrb_en   = gnt_b_vld;
    wra_idx  = gnt_a_vld ? src_tag[gnt_a_idx]  : PHYS_ZERO_REG;
    wrb_idx  = gnt_b_vld ? src_tag[gnt_b_idx]  : PHYS_ZERO_REG;
    wra_data = gnt_a_vld ? src_data[gnt_a_idx] : '0;
    wrb_data = gnt_b_vld ? src_data[gnt_b_idx] : '0;
    fu_ready = (~hold_valid_q | grant) & {NUM_FU{~arb_off}};
  end

  // Holding-register and pointer next state.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      hold_valid_d[i] = hold_valid_q[i] & ~grant[i];
      hold_tag_d[i]   = hold_tag_q[i];
      hold_data_d[i]  = hold_data_q[i];
      // A result granted straight off the input (empty port) is never held.
      if (fu_ready[i] && in_live[i] && !(grant[i] && !hold_valid_q[i])) begin
        hold_valid_d[i] = 1'b1;
        hold_tag_d[i]   = in_tag[i];
        hold_data_d[i]  = in_data[i];
      end
    end
    if (flush) begin
      hold_valid_d = '0;
    end
    rr_ptr_d = rr_ptr_q;
    if (gnt_b_vld) begin
      rr_ptr_d = gnt_b_idx + PTR_W'(1);
    end else if (gnt_a_vld) begin
      rr_ptr_d = gnt_a_idx + PTR_W'(1);
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  // Payload registers are qualified by hold_valid and need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      hold_tag_q[i]  <= hold_tag_d[i];
      hold_data_q[i] <= hold_data_d[i];
    end
  end

endmodule
`default_nettype wire
